// File: rtl/dbus_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_wait_responder
// Purpose  : Slave end of the CPU data bus. Serves one load or store at a time
//            from a local word-addressed RAM, granting in the request cycle
//            and holding WaitReq high for a fixed number of wait states per
//            transfer type before a one-cycle response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst_n      synchronous active-low reset
//   i_Req        transfer request
//   i_Addr       byte address (ADDR_W bits)
//   i_Wr         1 = store, 0 = load
//   i_WData      store data
//   i_ByteEn     store byte lanes
//   o_Gnt        request accepted this cycle (combinational)
//   o_WaitReq    responder busy, initiator holds its W stage
//   o_RData      load data, non-zero only in a load response cycle
//   o_RDataValid load response this cycle
//   o_Err        response for a misaligned / out-of-range transfer
// ============================================================================
module dbus_wait_responder #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 32,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Req,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic              i_Wr,
  input  logic [31:0]       i_WData,
  input  logic [3:0]        i_ByteEn,
  output logic              o_Gnt,
  output logic              o_WaitReq,
  output logic [31:0]       o_RData,
  output logic              o_RDataValid,
  output logic              o_Err
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]        C_RD_N    = 4'(READ_WAIT);
  localparam logic [3:0]        C_WR_N    = 4'(WRITE_WAIT);
  localparam logic [ADDR_W-3:0] C_DEPTH_W = (ADDR_W-2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        ram [DEPTH];

  logic               gnt;
  logic               acc_err;
  logic [IDX_W-1:0]   acc_idx;
  logic [3:0]         acc_n;

  logic               ram_we;
  logic [IDX_W-1:0]   ram_idx;
  logic [31:0]        ram_wdata;
  logic [3:0]         ram_be;

  // The RESP cycle doubles as an accept slot so transfers can run back-to-back.
  assign gnt = i_Req && ((state_q == S_IDLE) || (state_q == S_RESP)) && i_Rst_n;

  always_comb begin
    acc_err = (i_Addr[1:0] != 2'b00) || (i_Addr[ADDR_W-1:2] >= C_DEPTH_W);
    acc_idx = i_Addr[IDX_W+1:2];
    acc_n   = i_Wr ? C_WR_N : C_RD_N;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    err_d     = err_q;
    rdata_d   = 32'd0;
    ram_we    = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;
    ram_be    = be_q;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (gnt) begin
          idx_d   = acc_idx;
          wr_d    = i_Wr;
          wdata_d = i_WData;
          be_d    = i_ByteEn;
          err_d   = acc_err;
          if (acc_n != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = acc_n - 4'd1;
          end else begin
            // Zero wait states: commit / read straight from the request fields.
            state_d = S_RESP;
            if (i_Wr) begin
              ram_we    = !acc_err;
              ram_idx   = acc_idx;
              ram_wdata = i_WData;
              ram_be    = i_ByteEn;
            end else begin
              rdata_d = acc_err ? 32'd0 : ram[acc_idx];
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (wr_q) begin
            ram_we = !err_q;
          end else begin
            rdata_d = err_q ? 32'd0 : ram[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; a reset edge also blocks a pending commit.
  always_ff @(posedge i_Clk) begin
    if (i_Rst_n && ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_be[k]) begin
          ram[ram_idx][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
      end
    end
  end

  // Outputs are forced low while reset is asserted, even before the first edge.
  assign o_Gnt        = gnt;
  assign o_WaitReq    = (state_q == S_WAIT) && i_Rst_n;
  assign o_RDataValid = (state_q == S_RESP) && !wr_q && i_Rst_n;
  assign o_Err        = (state_q == S_RESP) && err_q && i_Rst_n;
  assign o_RData      = i_Rst_n ? rdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dbus_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_wait_responder
// Purpose  : Drives three responders (default waits, zero waits, long write
//            wait) from one shared stimulus stream and checks every output
//            every cycle against a transaction-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_wait_responder;

  localparam int DEPTH = 16;
  localparam int ND    = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, wr;
  logic [31:0] addr, wd;
  logic [3:0]  be;
  logic [ND-1:0] gnt, wreq, rv, er;
  logic [31:0] rd [ND];

  dbus_wait_responder #(.DEPTH(DEPTH), .ADDR_W(32), .READ_WAIT(2), .WRITE_WAIT(1)) u_dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Addr(addr), .i_Wr(wr),
    .i_WData(wd), .i_ByteEn(be), .o_Gnt(gnt[0]), .o_WaitReq(wreq[0]),
    .o_RData(rd[0]), .o_RDataValid(rv[0]), .o_Err(er[0]));

  dbus_wait_responder #(.DEPTH(DEPTH), .ADDR_W(32), .READ_WAIT(0), .WRITE_WAIT(0)) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Addr(addr), .i_Wr(wr),
    .i_WData(wd), .i_ByteEn(be), .o_Gnt(gnt[1]), .o_WaitReq(wreq[1]),
    .o_RData(rd[1]), .o_RDataValid(rv[1]), .o_Err(er[1]));

  dbus_wait_responder #(.DEPTH(DEPTH), .ADDR_W(32), .READ_WAIT(2), .WRITE_WAIT(3)) u_dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Addr(addr), .i_Wr(wr),
    .i_WData(wd), .i_ByteEn(be), .o_Gnt(gnt[2]), .o_WaitReq(wreq[2]),
    .o_RData(rd[2]), .o_RDataValid(rv[2]), .o_Err(er[2]));

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: each responder keeps at most one transaction, described
  // by its accept time and wait length; outputs follow from the timeline.
  int          rw_v [ND];
  int          ww_v [ND];
  int          cyc;
  bit          have [ND];
  int          acc  [ND];
  int          nw   [ND];
  bit          m_wr [ND];
  bit          m_err[ND];
  int          m_idx[ND];
  logic [31:0] m_wd [ND];
  logic [3:0]  m_be [ND];
  logic [31:0] mem  [ND][DEPTH];
  int          acc_cnt[ND];
  logic [31:0] cap  [ND];
  int          vcnt [ND];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] iv(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  task automatic step();
    bit          e_gnt [ND];
    bit          in_wait, is_resp;
    logic [31:0] e_rd;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      in_wait  = rst_n && have[d] && (cyc >= acc[d]) && (cyc < acc[d] + nw[d]);
      is_resp  = rst_n && have[d] && (cyc == acc[d] + nw[d]);
      e_gnt[d] = rst_n && req && !in_wait;
      e_rd     = (is_resp && !m_wr[d] && !m_err[d]) ? mem[d][m_idx[d]] : 32'd0;
      chk($sformatf("gnt%0d", d),   32'(gnt[d]),  32'(e_gnt[d]));
      chk($sformatf("wait%0d", d),  32'(wreq[d]), 32'(in_wait));
      chk($sformatf("valid%0d", d), 32'(rv[d]),   32'(is_resp && !m_wr[d]));
      chk($sformatf("err%0d", d),   32'(er[d]),   32'(is_resp && m_err[d]));
      chk($sformatf("rdata%0d", d), rd[d],        e_rd);
      if (rv[d] === 1'b1) begin
        cap[d] = rd[d];
        vcnt[d]++;
      end
    end
    // Effects of the coming rising edge.
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        have[d] = 1'b0;
      end else begin
        if (e_gnt[d]) begin
          have[d]  = 1'b1;
          acc[d]   = cyc + 1;
          m_wr[d]  = wr;
          m_err[d] = (addr % 4 != 0) || ((addr >> 2) >= DEPTH);
          m_idx[d] = int'((addr >> 2) % DEPTH);
          m_wd[d]  = wd;
          m_be[d]  = be;
          nw[d]    = wr ? ww_v[d] : rw_v[d];
          acc_cnt[d]++;
        end
        if (have[d] && m_wr[d] && !m_err[d] && (acc[d] + nw[d] == cyc + 1)) begin
          for (int k = 0; k < 4; k++)
            if (m_be[d][k]) mem[d][m_idx[d]][8*k +: 8] = m_wd[d][8*k +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit busy();
    bit b = 1'b0;
    for (int d = 0; d < ND; d++)
      if (have[d] && cyc <= acc[d] + nw[d]) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy() && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic xfer_all(input bit w, input logic [31:0] a,
                          input logic [31:0] dat, input logic [3:0] b);
    int  c0 [ND];
    int  t = 0;
    bit  all;
    for (int d = 0; d < ND; d++) c0[d] = acc_cnt[d];
    req = 1'b1; wr = w; addr = a; wd = dat; be = b;
    all = 1'b0;
    while (!all && t < 100) begin
      step();
      t++;
      all = 1'b1;
      for (int d = 0; d < ND; d++) if (acc_cnt[d] == c0[d]) all = 1'b0;
    end
    if (t >= 100) chk("xfer_timeout", 32'd0, 32'd1);
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    int v0;
    rw_v = '{2, 0, 2};
    ww_v = '{1, 0, 3};
    cyc = 0;
    for (int d = 0; d < ND; d++) begin
      have[d] = 1'b0; acc[d] = 0; nw[d] = 0; acc_cnt[d] = 0; vcnt[d] = 0;
      cap[d] = 32'd0; m_wr[d] = 1'b0; m_err[d] = 1'b0; m_idx[d] = 0;
    end

    // Reset held with a pending request: nothing is granted.
    rst_n = 1'b0; req = 1'b1; wr = 1'b1; addr = 32'h0; wd = iv(0); be = 4'hF;
    step();
    step();
    rst_n = 1'b1;
    step();
    req = 1'b0;
    wait_idle();

    // Known contents in every word.
    for (int i = 0; i < DEPTH; i++) xfer_all(1'b1, 32'(i * 4), iv(i), 4'hF);

    // Store then load at defaults.
    xfer_all(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    xfer_all(1'b0, 32'h10, 32'h0, 4'h0);
    chk("ld_deadbeef", cap[0], 32'hDEAD_BEEF);

    // Partial byte lanes.
    xfer_all(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
    xfer_all(1'b0, 32'h10, 32'h0, 4'h0);
    chk("ld_bytelane", cap[0], 32'hDE22_BE44);

    // Back-to-back loads; the zero-wait responder serves one per cycle.
    v0 = vcnt[1];
    req = 1'b1; wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i * 4);
      step();
    end
    req = 1'b0;
    wait_idle();
    chk("zw_valid_cnt", 32'(vcnt[1] - v0), 32'd4);

    // Error responses.
    xfer_all(1'b0, 32'h12, 32'h0, 4'h0);
    chk("ld_misaligned", cap[0], 32'h0);
    xfer_all(1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF);
    xfer_all(1'b0, 32'h0, 32'h0, 4'h0);
    chk("ld_word0_kept", cap[0], iv(0));

    // Reset in the second wait cycle of a long store abandons it.
    v0 = acc_cnt[2];
    req = 1'b1; wr = 1'b1; addr = 32'h20; wd = 32'hCAFE_F00D; be = 4'hF;
    step();
    chk("rst_acc", 32'(acc_cnt[2] - v0), 32'd1);
    req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_idle();
    xfer_all(1'b0, 32'h20, 32'h0, 4'h0);
    chk("ld_after_rst", cap[2], iv(8));
    chk("ld_committed", cap[1], 32'hCAFE_F00D);

    // Randomized traffic, including requests that change during wait states.
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      req   = $urandom_range(0, 1) != 0;
      wr    = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 7))
        0:       addr = 32'($urandom_range(0, 63)) | 32'd1 << $urandom_range(0, 1);
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      step();
    end
    rst_n = 1'b1;
    req = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
